// File: rtl/headerdec_pkg.sv
// Shared constants, state encoding and whitening step for the baseband
// header decoder (and its transmit-side counterpart).
package headerdec_pkg;

   localparam int HDR_BITS   = 18;
   localparam int FEC_REP    = 3;
   localparam int FIELD_BITS = 10;

   localparam int LT_ADDR_OFS = 0;
   localparam int TYPE_OFS    = 3;
   localparam int FLOW_OFS    = 7;
   localparam int ARQN_OFS    = 8;
   localparam int SEQN_OFS    = 9;
   localparam int HEC_OFS     = 10;

   // Galois feedback for D^7+D^4+1: w[6] folds into bit 4 on rotation.
   localparam logic [6:0] WHITEN_TAP = 7'h10;
   // D^8+D^7+D^5+D^2+D+1 with the D^8 term implicit.
   localparam logic [7:0] HEC_POLY   = 8'hA7;

   localparam logic [3:0] TYPE_NULL = 4'b0000;
   localparam logic [3:0] TYPE_POLL = 4'b0001;
   localparam logic [3:0] TYPE_FHS  = 4'b0010;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CHECK   = 2'd2,
      ST_DONE    = 2'd3
   } hdr_state_t;

   function automatic logic [6:0] whiten_step(input logic [6:0] w);
      return {w[5:0], w[6]} ^ (w[6] ? WHITEN_TAP : 7'h00);
   endfunction

endpackage

// File: rtl/hec_lfsr8.sv
// Serial 8-bit HEC register: seed load, one-bit shift, zero flag.
// Shared with the transmit encoder, which sends the register MSB first.
module hec_lfsr8
   import headerdec_pkg::*;
(
   input  logic       clk_6M,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       shift,
   input  logic       din,
   output logic       zero
);

   logic [7:0] hec_q;

   // Seed on load, otherwise divide one more bit through the polynomial.
   always_ff @(posedge clk_6M) begin
      if (rst) begin
         hec_q <= 8'h00;
      end else if (load) begin
         hec_q <= seed;
      end else if (shift) begin
         hec_q <= {hec_q[6:0], 1'b0} ^ ({8{din ^ hec_q[7]}} & HEC_POLY);
      end
   end

   assign zero = (hec_q == 8'h00);

endmodule

// File: rtl/rx_header_decoder.sv
// Receive header decoder: FEC1/3 majority vote, de-whitening, HEC check,
// field extraction and a single completion pulse.
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | waiting for header_st_p
// ST_COLLECT | sampling coded bits on p_1us, 54 in total
// ST_CHECK   | one cycle: latch fields, hec_good, lt_addressed, fec_corr
// ST_DONE    | one cycle: raise hdr_done_p on the way back to idle
module rx_header_decoder #(
   parameter int HDR_BITS = headerdec_pkg::HDR_BITS,
   parameter int FEC_REP  = headerdec_pkg::FEC_REP
) (
   input  logic       clk_6M,
   input  logic       rst,
   input  logic       p_1us,
   input  logic       header_st_p,
   input  logic       rx_abort,
   input  logic       rxbit,
   input  logic       whiten_en,
   input  logic [6:0] whiten_init,
   input  logic [7:0] hec_init,
   input  logic [2:0] ms_lt_addr,
   input  logic       ms_tslot_p,
   output logic       busy,
   output logic       hdr_done_p,
   output logic       hec_good,
   output logic       lt_addressed,
   output logic [2:0] lt_addr,
   output logic [3:0] pk_type,
   output logic       flow,
   output logic       arqn,
   output logic       seqn,
   output logic [4:0] fec_corr
);

   import headerdec_pkg::*;

   localparam logic [1:0] LAST_TRIP = 2'(FEC_REP - 1);
   localparam logic [4:0] LAST_BIT  = 5'(HDR_BITS - 1);
   localparam logic [4:0] FIELD_CNT = 5'(FIELD_BITS);

   hdr_state_t       state;
   logic [1:0]       trip_cnt;
   logic [1:0]       ones;
   logic [4:0]       bit_cnt;
   logic [4:0]       fec_work;
   logic [6:0]       w;
   logic             wen_q;
   logic [9:0]       fld_work;

   logic [1:0]       ones_sum;
   logic             last_trip;
   logic             d_bit;
   logic             b_bit;
   logic             corr;
   logic             hec_shift;
   logic             hec_zero;

   assign ones_sum  = ones + {1'b0, rxbit};
   assign last_trip = (trip_cnt == LAST_TRIP);
   assign d_bit     = ones_sum[1];
   assign corr      = (ones_sum == 2'd1) || (ones_sum == 2'd2);
   assign b_bit     = d_bit ^ (wen_q & w[6]);
   assign hec_shift = (state == ST_COLLECT) && p_1us && last_trip
                      && !header_st_p && !rx_abort;
   assign busy      = (state == ST_COLLECT) || (state == ST_CHECK);

   hec_lfsr8 u_hec (
      .clk_6M (clk_6M),
      .rst    (rst),
      .load   (header_st_p),
      .seed   (hec_init),
      .shift  (hec_shift),
      .din    (b_bit),
      .zero   (hec_zero)
   );

   // Header FSM: vote/de-whiten per triple, then latch results and pulse.
   always_ff @(posedge clk_6M) begin
      if (rst) begin
         state        <= ST_IDLE;
         trip_cnt     <= 2'd0;
         ones         <= 2'd0;
         bit_cnt      <= 5'd0;
         fec_work     <= 5'd0;
         w            <= 7'h00;
         wen_q        <= 1'b0;
         fld_work     <= 10'h000;
         hdr_done_p   <= 1'b0;
         hec_good     <= 1'b0;
         lt_addressed <= 1'b0;
         lt_addr      <= 3'd0;
         pk_type      <= 4'd0;
         flow         <= 1'b0;
         arqn         <= 1'b0;
         seqn         <= 1'b0;
         fec_corr     <= 5'd0;
      end else begin
         hdr_done_p <= 1'b0;
         // A CHECK update later in this block overrides the slot clear.
         if (ms_tslot_p) lt_addressed <= 1'b0;

         if (header_st_p) begin
            state    <= ST_COLLECT;
            trip_cnt <= 2'd0;
            ones     <= 2'd0;
            bit_cnt  <= 5'd0;
            fec_work <= 5'd0;
            fld_work <= 10'h000;
            w        <= whiten_init;
            wen_q    <= whiten_en;
         end else if (rx_abort) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_COLLECT: begin
                  if (p_1us) begin
                     if (last_trip) begin
                        trip_cnt <= 2'd0;
                        ones     <= 2'd0;
                        if (corr) fec_work <= fec_work + 5'd1;
                        w <= whiten_step(w);
                        // Fields arrive LSB first; shift right so bit 0 lands last.
                        if (bit_cnt < FIELD_CNT) fld_work <= {b_bit, fld_work[9:1]};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == LAST_BIT) state <= ST_CHECK;
                     end else begin
                        trip_cnt <= trip_cnt + 2'd1;
                        ones     <= ones_sum;
                     end
                  end
               end
               ST_CHECK: begin
                  hec_good     <= hec_zero;
                  lt_addressed <= hec_zero && (fld_work[LT_ADDR_OFS +: 3] == ms_lt_addr);
                  lt_addr      <= fld_work[LT_ADDR_OFS +: 3];
                  pk_type      <= fld_work[TYPE_OFS +: 4];
                  flow         <= fld_work[FLOW_OFS];
                  arqn         <= fld_work[ARQN_OFS];
                  seqn         <= fld_work[SEQN_OFS];
                  fec_corr     <= fec_work;
                  state        <= ST_DONE;
               end
               ST_DONE: begin
                  hdr_done_p <= 1'b1;
                  state      <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/rx_header_decoder.md
# rx_header_decoder

Receive-side packet-header decoder for the baseband. After the access-code trailer, it takes the 54-bit FEC1/3-coded, whitened header one bit per microsecond. It majority-decodes each bit triple, de-whitens the result and checks the HEC, then presents the LT_ADDR, TYPE, FLOW, ARQN and SEQN fields with a single completion pulse. It is the counterpart of the transmit header encoder and feeds the link-control and ARQ logic.

## Interface
Parameters:
- HDR_BITS, 18, decoded header length (10 field bits + 8 HEC bits)
- FEC_REP, 3, repetition factor of the FEC1/3 code

Ports:
- clk_6M  in  1  6 MHz system clock
- rst  in  1  synchronous, active-high reset
- p_1us  in  1  one-cycle bit strobe, once per microsecond
- header_st_p  in  1  one-cycle pulse; the header's first coded bit arrives on the next p_1us
- rx_abort  in  1  abandon the decode in progress (slot end, sync loss)
- rxbit  in  1  received coded bit, valid when p_1us is high
- whiten_en  in  1  de-whitening enable, sampled at header_st_p
- whiten_init  in  7  whitening seed {CLK[6:1],1'b1}, loaded at header_st_p
- hec_init  in  8  HEC seed (UAP), loaded at header_st_p
- ms_lt_addr  in  3  own/expected LT_ADDR
- ms_tslot_p  in  1  slot-boundary pulse
- busy  out  1  decode in progress
- hdr_done_p  out  1  one-cycle pulse, fields valid
- hec_good  out  1  HEC remainder was zero
- lt_addressed  out  1  hec_good and lt_addr==ms_lt_addr
- lt_addr  out  3  decoded LT_ADDR
- pk_type  out  4  decoded TYPE
- flow, arqn, seqn  out  1 each  decoded flags
- fec_corr  out  5  triples not unanimous (0..18)

## Operation
- FSM has four states: IDLE, COLLECT, CHECK, DONE.
- **IDLE → COLLECT** on header_st_p. On the same edge:
  - clear trip_cnt (2b), bit_cnt (5b), the vote accumulator and the fec_corr working counter;
  - load the whitening register w←whiten_init and the HEC register h←hec_init.
- **COLLECT, each p_1us:**
  - Add rxbit to a 2-bit ones count and increment trip_cnt.
  - On the third bit, the decoded bit d = (ones ≥ 2). If ones is 1 or 2, increment fec_corr.
  - De-whitening: b = d ^ (whiten_en & w[6]). Advance w as a Galois LFSR for D^7+D^4+1: w←{w[5:0],w[6]} with bit 4 = w[3]^w[6].
  - HEC: fb = b ^ h[7]. New h[0]=fb; h[i]=h[i-1]^fb for i∈{1,2,5,7}; other bits shift plainly. This is polynomial D^8+D^7+D^5+D^2+D+1.
  - Field bits are taken LSB-first: bits 0-2 lt_addr, 3-6 pk_type, 7 flow, 8 arqn, 9 seqn, 10-17 HEC (h[7] first at the transmitter).
  - bit_cnt increments; after decoded bit 17, go to CHECK.
- **CHECK** lasts one cycle, then goes to DONE:
  - hec_good←(h==0);
  - lt_addressed←(h==0)&(lt_addr_work==ms_lt_addr);
  - latch all field outputs and fec_corr.
- **DONE** lasts one cycle: hdr_done_p=1, then IDLE.
- **rx_abort** in any state goes to IDLE with no pulse; outputs keep their previous values.
- **header_st_p in COLLECT/CHECK/DONE** restarts (re-seeds, returns to COLLECT); a pending done pulse is dropped. header_st_p wins over rx_abort.
- **ms_tslot_p** clears lt_addressed, unless the CHECK update happens on the same cycle, in which case the update wins.
- busy is high in COLLECT and CHECK.

## Timing
- Reset: state IDLE; all outputs 0; w=0, h=0.
- A p_1us coincident with header_st_p is not sampled.
- Exactly 54 p_1us samples are taken in COLLECT. Gaps between p_1us are arbitrary (≥1 cycle).
- hdr_done_p is asserted 2 clk_6M cycles after the clock edge that samples coded bit 54.
- Field outputs and hec_good change only in CHECK and are stable from hdr_done_p until the next CHECK.

## Structure
- Package headerdec_pkg holds:
  - WHITEN_TAP, HEC_POLY=8'hA7, field offsets, HDR_BITS, FEC_REP;
  - state enum;
  - TYPE constants NULL=4'b0000, POLL=4'b0001, FHS=4'b0010.
- One sub-module, hec_lfsr8: seed load, serial shift, zero flag. Reusable by the encoder.
- The whitening LFSR stays inline.

## Test plan
- **Clean header:** whiten_en=0, hec_init=8'h00, lt_addr=3'b101, pk_type=POLL, flow=1, arqn=0, seqn=1, valid HEC, triples unanimous → hdr_done_p once; fields match; hec_good=1; fec_corr=0; lt_addressed=1 with ms_lt_addr=5.
- **Single-bit errors:** same header with one bit flipped in each of 18 triples → identical fields, hec_good=1, fec_corr=18.
- **Whitening:** whiten_en=1, whiten_init=7'h3F, stream whitened by the reference model → fields recovered, hec_good=1. The same stream with whiten_en=0 → hec_good=0.
- **HEC and address mismatch:** flip two bits of one triple in HEC bit 12 → hec_good=0, lt_addressed=0. A valid header with lt_addr=2 and ms_lt_addr=5 → hec_good=1, lt_addressed=0.
- **Abort and restart:**
  - rx_abort after 30 samples → no hdr_done_p, previous outputs held.
  - header_st_p after 40 samples, then a full header → exactly one hdr_done_p with the second header's fields.
- **Reset and slot:**
  - rst mid-COLLECT → all outputs 0, IDLE next cycle.
  - ms_tslot_p after a good decode → lt_addressed 0 next cycle.
